uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 89 ++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART: buffers words from the receiver's done tick, first-word-fall-through read.
// Optional level output is enabled by defining UART_RX_FIFO_LEVEL_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_tick,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd,
  input  logic                 clr_ovf,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_BITS:0]   level
`endif
);

  localparam int                DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wptr_q, wptr_d;
  logic [ADDR_BITS-1:0] rptr_q, rptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 wr_acc, rd_acc, wr_drop;

  // Flags come straight from the count register, so the strobes never reach them combinationally.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // A pop on a full FIFO frees the slot the same edge, so the write still goes in.
  assign wr_acc  = wr_tick && (!full || rd);
  assign rd_acc  = rd && !empty;
  assign wr_drop = wr_tick && full && !rd;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    if (wr_drop)      overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; stale words are masked by empty.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data  = empty ? '0 : mem_q[rptr_q];
  assign overflow = overflow_q;

`ifdef UART_RX_FIFO_LEVEL_EN
  assign level = count_q;
`endif

endmodule
